eth_rx_deserializer: RTL

Receive-side front end of the Ethernet interface. It synchronises the SPI bus from the Ethernet controller into the system clock domain, assembles MISO bits into bytes, and writes each byte into the receive buffer with its own address counter and an active-low write strobe. Its `d`, `a` and `n_recv_buf_we` outputs drive the downstream MAC filter directly. It consumes the filter's `n_inhibit` to stop storing frames not addressed to us.

---
 rtl/eth_rx_deserializer.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_deserializer.sv
// eth_rx_deserializer
// Receive front end of the Ethernet interface. Brings the controller's SPI bus
// into the clk domain and assembles MISO bits (mode 0, MSB first) into bytes.
// Each byte is written to the receive buffer with a WE_LEN-cycle active-low
// strobe at its own address. A frame is stopped from storing when the MAC
// filter deasserts n_inhibit, or when the buffer is full.
//
// Build option: define ETH_RX_LEN_CAPTURE_EN to build the rx_len register.
// Without it, rx_len is tied to zero.
//
// Ports
//   clk, rst       system clock; synchronous active-high reset
//   n_ss_in        SPI slave select (asynchronous)
//   sck, miso      SPI clock and data (asynchronous)
//   n_inhibit      MAC filter verdict; low drops the rest of the frame
//   n_ss           synchronised slave select, fed to the filter
//   d, a_full, a   write data, full write address, low address nibble
//   n_recv_buf_we  active-low buffer write strobe
//   frame_done     one-cycle pulse at frame end
//   frame_ok       frame status, valid with frame_done
//   overflow       buffer filled during the current or last frame
//   rx_len         bytes stored in the last frame
module eth_rx_deserializer #(
    parameter int unsigned BUF_ADDR_W = 11,
    parameter int unsigned WE_LEN     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  n_ss_in,
    input  logic                  sck,
    input  logic                  miso,
    input  logic                  n_inhibit,
    output logic                  n_ss,
    output logic [7:0]            d,
    output logic [BUF_ADDR_W-1:0] a_full,
    output logic [3:0]            a,
    output logic                  n_recv_buf_we,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic                  overflow,
    output logic [BUF_ADDR_W:0]   rx_len
);

    localparam int unsigned CNT_W = BUF_ADDR_W + 1;
    localparam int unsigned WC_W  = 3;
    localparam logic [WC_W-1:0]  WE_LEN_C = WC_W'(WE_LEN);
    localparam logic [CNT_W-1:0] INH_MIN  = CNT_W'(6);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_STROBE  = 3'd2,
        S_ADVANCE = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic n_ss_s1, n_ss_d;
    logic sck_s1, sck_s2, sck_d;
    logic miso_s1, miso_s2;
    logic sck_rise, ss_fall, ss_rise;

    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [7:0] byte_val;

    logic [CNT_W-1:0]      strobe_cnt, strobe_cnt_nxt, cnt_inc;
    logic [WC_W-1:0]       st_cnt, st_cnt_nxt;
    logic                  end_pend, end_pend_nxt;
    logic                  drop_inh, drop_inh_nxt;
    logic                  inh_seen, inh_seen_nxt;
    logic                  buf_full, adv_inh, ok_now;
    logic [7:0]            d_nxt;
    logic [BUF_ADDR_W-1:0] a_full_nxt;
    logic                  we_n_nxt, frame_done_nxt, frame_ok_nxt, overflow_nxt;

    // Two-flop synchronisers plus one extra stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            n_ss_s1 <= 1'b1;
            n_ss    <= 1'b1;
            n_ss_d  <= 1'b1;
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            n_ss_s1 <= n_ss_in;
            n_ss    <= n_ss_s1;
            n_ss_d  <= n_ss;
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_d;
    assign ss_fall  = n_ss_d & ~n_ss;
    assign ss_rise  = ~n_ss_d & n_ss;

    // Bit capture runs in every in-frame state; leaving the frame aborts a partial byte
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sck_rise) begin
            shreg   <= {shreg[5:0], miso_s2};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // The eighth bit goes straight from the synchroniser into the byte
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign byte_val  = {shreg, miso_s2};

    // Top count bit set means every buffer address has been written this frame
    assign buf_full = strobe_cnt[BUF_ADDR_W];
    assign cnt_inc  = strobe_cnt + CNT_W'(1);
    assign adv_inh  = ~n_inhibit && (cnt_inc >= INH_MIN);
    // An overflow-only drop is still good unless the filter objected at any point
    assign ok_now   = ~drop_inh & ~(overflow & (inh_seen | ~n_inhibit));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ss_fall) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (ss_rise) begin
                    state_nxt = S_IDLE;
                end else if (byte_done) begin
                    state_nxt = buf_full ? S_DROP : S_STROBE;
                end
            end
            S_STROBE: begin
                // Frame end here is deferred until the strobe and address step finish
                if (st_cnt == WE_LEN_C) state_nxt = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (ss_rise || end_pend) begin
                    state_nxt = S_IDLE;
                end else if (adv_inh) begin
                    state_nxt = S_DROP;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_DROP: begin
                if (ss_rise) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        d_nxt          = d;
        a_full_nxt     = a_full;
        we_n_nxt       = 1'b1;
        frame_done_nxt = 1'b0;
        frame_ok_nxt   = frame_ok;
        overflow_nxt   = overflow;
        strobe_cnt_nxt = strobe_cnt;
        st_cnt_nxt     = st_cnt;
        end_pend_nxt   = end_pend;
        drop_inh_nxt   = drop_inh;
        inh_seen_nxt   = inh_seen;

        if (state != S_IDLE && !n_inhibit) inh_seen_nxt = 1'b1;

        case (state)
            S_IDLE: begin
                a_full_nxt     = '0;
                strobe_cnt_nxt = '0;
                st_cnt_nxt     = '0;
                end_pend_nxt   = 1'b0;
                drop_inh_nxt   = 1'b0;
                inh_seen_nxt   = 1'b0;
                if (ss_fall) overflow_nxt = 1'b0;
            end
            S_SHIFT: begin
                if (ss_rise) begin
                    frame_done_nxt = 1'b1;
                    frame_ok_nxt   = ok_now;
                end else if (byte_done) begin
                    if (buf_full) begin
                        overflow_nxt = 1'b1;
                    end else begin
                        d_nxt      = byte_val;
                        st_cnt_nxt = '0;
                    end
                end
            end
            S_STROBE: begin
                st_cnt_nxt = st_cnt + WC_W'(1);
                we_n_nxt   = (st_cnt == WE_LEN_C);
                if (ss_rise) end_pend_nxt = 1'b1;
            end
            S_ADVANCE: begin
                a_full_nxt     = a_full + BUF_ADDR_W'(1);
                strobe_cnt_nxt = cnt_inc;
                if (ss_rise || end_pend) begin
                    frame_done_nxt = 1'b1;
                    frame_ok_nxt   = ok_now;
                end else if (adv_inh) begin
                    drop_inh_nxt = 1'b1;
                end
            end
            S_DROP: begin
                if (ss_rise) begin
                    frame_done_nxt = 1'b1;
                    frame_ok_nxt   = ok_now;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and frame bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            d             <= '0;
            a_full        <= '0;
            n_recv_buf_we <= 1'b1;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            overflow      <= 1'b0;
            strobe_cnt    <= '0;
            st_cnt        <= '0;
            end_pend      <= 1'b0;
            drop_inh      <= 1'b0;
            inh_seen      <= 1'b0;
        end else begin
            d             <= d_nxt;
            a_full        <= a_full_nxt;
            n_recv_buf_we <= we_n_nxt;
            frame_done    <= frame_done_nxt;
            frame_ok      <= frame_ok_nxt;
            overflow      <= overflow_nxt;
            strobe_cnt    <= strobe_cnt_nxt;
            st_cnt        <= st_cnt_nxt;
            end_pend      <= end_pend_nxt;
            drop_inh      <= drop_inh_nxt;
            inh_seen      <= inh_seen_nxt;
        end
    end

    assign a = a_full[3:0];

`ifdef ETH_RX_LEN_CAPTURE_EN
    logic [CNT_W-1:0] end_cnt;
    logic [CNT_W-1:0] rx_len_q;

    // A frame ending in ADVANCE includes the strobe just completed
    assign end_cnt = (state == S_ADVANCE) ? cnt_inc : strobe_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_len_q <= '0;
        end else if (frame_done_nxt) begin
            rx_len_q <= end_cnt;
        end
    end

    assign rx_len = rx_len_q;
`else
    assign rx_len = '0;
`endif

endmodule
